// File: rtl/inference_rx_scheduler.sv
// One-at-a-time inference sequencer: accepts a received frame, runs the
// accelerator, hands the result to the reply transmitter, and keeps stats.
module inference_rx_scheduler #(
    parameter int RESULT_W       = 8,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                ENABLE,
    input  logic                RX_FRAME_READY,
    input  logic [31:0]         RX_SRC_IP,
    input  logic [47:0]         RX_SRC_MAC,
    input  logic [7:0]          RX_META,
    output logic                RX_HOLD,
    output logic                ACC_START,
    input  logic                ACC_DONE,
    input  logic [RESULT_W-1:0] ACC_RESULT,
    output logic                TX_VALID,
    input  logic                TX_READY,
    output logic [31:0]         TX_DST_IP,
    output logic [47:0]         TX_DST_MAC,
    output logic [7:0]          TX_META,
    output logic [RESULT_W-1:0] TX_RESULT,
    input  logic                TX_DONE,
    output logic [CNT_W-1:0]    FRAMES_SERVED,
    output logic [CNT_W-1:0]    FRAMES_DROPPED,
    output logic [CNT_W-1:0]    ACC_TIMEOUTS
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_BUSY    = 3'd2;
    localparam logic [2:0] S_TX_REQ  = 3'd3;
    localparam logic [2:0] S_TX_WAIT = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [31:0]         ip_q, ip_d;
    logic [47:0]         mac_q, mac_d;
    logic [7:0]          meta_q, meta_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]    served_q, served_d;
    logic [CNT_W-1:0]    dropped_q, dropped_d;
    logic [CNT_W-1:0]    timeouts_q, timeouts_d;
    logic                accept;

    assign accept = RX_FRAME_READY && ENABLE && (state_q == S_IDLE);

    always_comb begin
        state_d    = state_q;
        ip_d       = ip_q;
        mac_d      = mac_q;
        meta_d     = meta_q;
        result_d   = result_q;
        to_cnt_d   = to_cnt_q;
        served_d   = served_q;
        dropped_d  = dropped_q;
        timeouts_d = timeouts_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ip_d    = RX_SRC_IP;
                    mac_d   = RX_SRC_MAC;
                    meta_d  = RX_META;
                    state_d = S_START;
                end
            end
            S_START: begin
                to_cnt_d = '0;
                state_d  = S_BUSY;
            end
            S_BUSY: begin
                // A result arriving in the final cycle beats the timeout.
                if (ACC_DONE) begin
                    result_d = ACC_RESULT;
                    state_d  = S_TX_REQ;
                end else if (to_cnt_q == TO_LAST) begin
                    if (timeouts_q != '1) timeouts_d = timeouts_q + 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_TX_REQ: begin
                if (TX_READY) state_d = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (TX_DONE) begin
                    if (served_q != '1) served_d = served_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (RX_FRAME_READY && !accept && dropped_q != '1)
            dropped_d = dropped_q + 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= S_IDLE;
            ip_q       <= '0;
            mac_q      <= '0;
            meta_q     <= '0;
            result_q   <= '0;
            to_cnt_q   <= '0;
            served_q   <= '0;
            dropped_q  <= '0;
            timeouts_q <= '0;
        end else begin
            state_q    <= state_d;
            ip_q       <= ip_d;
            mac_q      <= mac_d;
            meta_q     <= meta_d;
            result_q   <= result_d;
            to_cnt_q   <= to_cnt_d;
            served_q   <= served_d;
            dropped_q  <= dropped_d;
            timeouts_q <= timeouts_d;
        end
    end

    assign RX_HOLD        = (state_q != S_IDLE);
    assign ACC_START      = (state_q == S_START);
    assign TX_VALID       = (state_q == S_TX_REQ);
    assign TX_DST_IP      = ip_q;
    assign TX_DST_MAC     = mac_q;
    assign TX_META        = meta_q;
    assign TX_RESULT      = result_q;
    assign FRAMES_SERVED  = served_q;
    assign FRAMES_DROPPED = dropped_q;
    assign ACC_TIMEOUTS   = timeouts_q;

endmodule

// File: tb/tb_inference_rx_scheduler.sv
// Transaction-level randomized bench for inference_rx_scheduler.
// Expected timing and counters come from per-transaction arithmetic.
module tb_inference_rx_scheduler;

    localparam int RW  = 8;
    localparam int CW  = 3;
    localparam int TO  = 20;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 0;
    logic          areset = 0;
    logic          enable = 0;
    logic          rx_ready = 0;
    logic [31:0]   rx_ip = 0;
    logic [47:0]   rx_mac = 0;
    logic [7:0]    rx_meta = 0;
    logic          rx_hold;
    logic          acc_start;
    logic          acc_done = 0;
    logic [RW-1:0] acc_result = 0;
    logic          tx_valid;
    logic          tx_ready = 0;
    logic [31:0]   tx_ip;
    logic [47:0]   tx_mac;
    logic [7:0]    tx_meta;
    logic [RW-1:0] tx_result;
    logic          tx_done = 0;
    logic [CW-1:0] served;
    logic [CW-1:0] dropped;
    logic [CW-1:0] timeouts;

    int vectors = 0;
    int miscompares = 0;
    int exp_served = 0;
    int exp_dropped = 0;
    int exp_to = 0;

    inference_rx_scheduler #(
        .RESULT_W(RW), .CNT_W(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK(clk), .ARESET(areset), .ENABLE(enable),
        .RX_FRAME_READY(rx_ready), .RX_SRC_IP(rx_ip),
        .RX_SRC_MAC(rx_mac), .RX_META(rx_meta), .RX_HOLD(rx_hold),
        .ACC_START(acc_start), .ACC_DONE(acc_done),
        .ACC_RESULT(acc_result), .TX_VALID(tx_valid),
        .TX_READY(tx_ready), .TX_DST_IP(tx_ip), .TX_DST_MAC(tx_mac),
        .TX_META(tx_meta), .TX_RESULT(tx_result), .TX_DONE(tx_done),
        .FRAMES_SERVED(served), .FRAMES_DROPPED(dropped),
        .ACC_TIMEOUTS(timeouts)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v < MAXC) ? v + 1 : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        rx_ip   = $urandom;
        rx_mac  = {16'($urandom), $urandom};
        rx_meta = 8'($urandom);
    endtask

    // One full transaction. acc_delay > TO means the accelerator never answers.
    task automatic run_txn(input logic [31:0] ip, input logic [47:0] mac,
                           input logic [7:0] meta, input logic [RW-1:0] res,
                           input int acc_delay, input int rdy_wait,
                           input int drop_at, input int done_wait);
        int n;
        bit hit;
        hit = (acc_delay <= TO);
        n = hit ? acc_delay : TO;
        enable = 1;
        rx_ready = 1;
        rx_ip = ip;
        rx_mac = mac;
        rx_meta = meta;
        step();
        rx_ready = 0;
        scramble();
        enable = 1'($urandom_range(0, 1));
        vectors++;
        if (acc_start !== 1'b1 || rx_hold !== 1'b1 || tx_ip !== ip) begin
            miscompares++;
            $display("FAIL start: acc_start=%b hold=%b ip=%h want 1 1 %h",
                     acc_start, rx_hold, tx_ip, ip);
        end
        step();
        vectors++;
        if (acc_start !== 1'b0) begin
            miscompares++;
            $display("FAIL start_pulse: acc_start=%b want 0", acc_start);
        end
        for (int i = 1; i <= n; i++) begin
            if (i == drop_at) begin
                rx_ready = 1;
                exp_dropped = sat(exp_dropped);
            end
            acc_done = (hit && i == n);
            acc_result = acc_done ? res : RW'($urandom);
            step();
            rx_ready = 0;
            acc_done = 0;
            scramble();
            if (i < n) begin
                vectors++;
                if (rx_hold !== 1'b1 || tx_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL busy[%0d]: hold=%b valid=%b want 1 0",
                             i, rx_hold, tx_valid);
                end
            end
        end
        if (!hit) begin
            exp_to = sat(exp_to);
            vectors++;
            if (rx_hold !== 1'b0 || tx_valid !== 1'b0 ||
                int'(timeouts) != exp_to || int'(dropped) != exp_dropped) begin
                miscompares++;
                $display("FAIL timeout: hold=%b valid=%b to=%0d drop=%0d want 0 0 %0d %0d",
                         rx_hold, tx_valid, timeouts, dropped, exp_to, exp_dropped);
            end
            enable = 1;
            return;
        end
        vectors++;
        if (tx_valid !== 1'b1 || tx_ip !== ip || tx_mac !== mac ||
            tx_meta !== meta || tx_result !== res || int'(timeouts) != exp_to) begin
            miscompares++;
            $display("FAIL tx_req: v=%b ip=%h mac=%h meta=%h r=%h to=%0d want 1 %h %h %h %h %0d",
                     tx_valid, tx_ip, tx_mac, tx_meta, tx_result, timeouts,
                     ip, mac, meta, res, exp_to);
        end
        for (int w = 0; w < rdy_wait; w++) begin
            tx_ready = 0;
            tx_done = (w == 0);
            step();
            tx_done = 0;
            vectors++;
            if (tx_valid !== 1'b1 || tx_ip !== ip || tx_mac !== mac ||
                tx_meta !== meta || tx_result !== res) begin
                miscompares++;
                $display("FAIL tx_stall[%0d]: v=%b ip=%h r=%h want 1 %h %h",
                         w, tx_valid, tx_ip, tx_result, ip, res);
            end
        end
        tx_ready = 1;
        step();
        tx_ready = 0;
        vectors++;
        if (tx_valid !== 1'b0 || rx_hold !== 1'b1) begin
            miscompares++;
            $display("FAIL tx_accept: v=%b hold=%b want 0 1", tx_valid, rx_hold);
        end
        for (int d = 0; d < done_wait; d++) begin
            acc_done = 1;
            acc_result = RW'($urandom);
            step();
            acc_done = 0;
            vectors++;
            if (rx_hold !== 1'b1 || tx_valid !== 1'b0 || tx_result !== res) begin
                miscompares++;
                $display("FAIL tx_wait[%0d]: hold=%b v=%b r=%h want 1 0 %h",
                         d, rx_hold, tx_valid, tx_result, res);
            end
        end
        tx_done = 1;
        step();
        tx_done = 0;
        exp_served = sat(exp_served);
        vectors++;
        if (rx_hold !== 1'b0 || int'(served) != exp_served ||
            int'(dropped) != exp_dropped || int'(timeouts) != exp_to) begin
            miscompares++;
            $display("FAIL tx_done: hold=%b srv=%0d drop=%0d to=%0d want 0 %0d %0d %0d",
                     rx_hold, served, dropped, timeouts,
                     exp_served, exp_dropped, exp_to);
        end
        enable = 1;
    endtask

    task automatic test_reset();
        areset = 1;
        step();
        step();
        areset = 0;
        exp_served = 0;
        exp_dropped = 0;
        exp_to = 0;
        vectors++;
        if (rx_hold !== 0 || acc_start !== 0 || tx_valid !== 0 ||
            tx_ip !== 0 || tx_mac !== 0 || tx_meta !== 0 || tx_result !== 0 ||
            served !== 0 || dropped !== 0 || timeouts !== 0) begin
            miscompares++;
            $display("FAIL reset: hold=%b st=%b v=%b ip=%h srv=%0d drop=%0d to=%0d want all 0",
                     rx_hold, acc_start, tx_valid, tx_ip, served, dropped, timeouts);
        end
    endtask

    task automatic test_basic();
        run_txn(32'h0A00_0002, 48'h0011_2233_4455, 8'h01, 8'h07, 15, 0, 0, 3);
    endtask

    task automatic test_drop_busy();
        run_txn(32'hC0A8_0105, 48'hAABB_CCDD_EEFF, 8'h5A, 8'h3C, 12, 2, 5, 2);
    endtask

    task automatic test_timeout();
        run_txn(32'h0A00_0003, 48'h0102_0304_0506, 8'h02, 8'h11, TO + 5, 0, 3, 0);
        run_txn(32'h0A00_0004, 48'h0605_0403_0201, 8'h03, 8'h99, TO, 1, 0, 1);
    endtask

    task automatic test_tx_stall();
        run_txn(32'h0A00_0005, 48'h1234_5678_9ABC, 8'h7E, 8'hE1, 5, 10, 0, 1);
    endtask

    task automatic test_disabled();
        enable = 0;
        for (int i = 0; i < 9; i++) begin
            rx_ready = 1;
            scramble();
            step();
            rx_ready = 0;
            exp_dropped = sat(exp_dropped);
            vectors++;
            if (acc_start !== 1'b0 || rx_hold !== 1'b0 ||
                int'(dropped) != exp_dropped) begin
                miscompares++;
                $display("FAIL disabled[%0d]: st=%b hold=%b drop=%0d want 0 0 %0d",
                         i, acc_start, rx_hold, dropped, exp_dropped);
            end
        end
        enable = 1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            run_txn($urandom, {16'($urandom), $urandom}, 8'($urandom),
                    RW'($urandom), $urandom_range(1, TO + 6),
                    $urandom_range(0, 4), $urandom_range(0, TO),
                    $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid();
        enable = 1;
        rx_ready = 1;
        rx_ip = 32'hDEAD_BEEF;
        step();
        rx_ready = 0;
        step();
        acc_done = 1;
        acc_result = 8'h42;
        step();
        acc_done = 0;
        tx_ready = 1;
        step();
        tx_ready = 0;
        areset = 1;
        step();
        areset = 0;
        exp_served = 0;
        exp_dropped = 0;
        exp_to = 0;
        vectors++;
        if (rx_hold !== 0 || tx_valid !== 0 || tx_ip !== 0 ||
            tx_result !== 0 || served !== 0 || dropped !== 0 || timeouts !== 0) begin
            miscompares++;
            $display("FAIL reset_mid: hold=%b v=%b ip=%h r=%h srv=%0d drop=%0d to=%0d want all 0",
                     rx_hold, tx_valid, tx_ip, tx_result, served, dropped, timeouts);
        end
        tx_done = 1;
        step();
        tx_done = 0;
        vectors++;
        if (rx_hold !== 0 || served !== 0) begin
            miscompares++;
            $display("FAIL late_done: hold=%b srv=%0d want 0 0", rx_hold, served);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop_busy();
        test_timeout();
        test_tx_stall();
        test_disabled();
        test_back_to_back();
        test_reset_mid();
        test_basic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
